sys_timer_responder: RTL and testbench
======================================

Name: sys_timer_responder

Overview:
- Responder (target) side of the CPU's system bus (sys_r_addr/sys_w_addr/sys_w_line/sys_read/sys_write/sys_r_line).
- Decodes a small memory-mapped register window containing an ID word, a scratch register, a free-running cycle counter and a down-counting timer with auto-reload and interrupt.
- Flags accesses that fall outside the window or are misaligned via a registered exception pulse.
- Sits beside the embedded RAM, driven directly by the memory_op stage outputs.

Parameters:
- BASE_ADDR, 32'h0000_0100, word-aligned base of the 32-byte register window.
- ID_VALUE, 32'hC032_0001, constant returned by the ID register.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous active-low reset.
- sys_r_addr  input  32  read byte address.
- sys_w_addr  input  32  write byte address.
- sys_w_line  input  32  write data.
- sys_read  input  1  read strobe, one cycle per access.
- sys_write  input  1  write strobe, one cycle per access.
- sys_r_line  output  32  registered read data.
- exc  output  1  registered bus exception pulse.
- irq  output  1  timer interrupt request (level).

Behaviour:
- Reset (rst==0 at a clk edge): sys_r_line=0, exc=0, irq=0, CTRL=0, COUNT=0, RELOAD=0, STATUS=0, SCRATCH=0, CYCLE=0. Reset overrides any access or timer event in the same cycle.
- Register offsets from BASE_ADDR:
  - 0x00 ID (RO, ID_VALUE)
  - 0x04 CTRL (bit0 EN, bit1 AUTO, bit2 IE; bits 31:3 read 0, writes ignored)
  - 0x08 COUNT (RW)
  - 0x0C RELOAD (RW)
  - 0x10 STATUS (bit0 EXP; write-1-to-clear)
  - 0x14 SCRATCH (RW)
  - 0x18 CYCLE (RO, free-running, +1 every cycle, wraps 32'hFFFF_FFFF -> 0)
  - 0x1C reserved: reads 0, writes ignored, no exception.
- Address valid: BASE_ADDR <= addr <= BASE_ADDR+0x1F and addr[1:0]==2'b00. Offset = addr[4:2].
- Read:
  - sys_read=1 at edge N -> sys_r_line holds the register value sampled before edge N, valid after edge N.
  - sys_r_line holds its value until the next read.
  - Invalid read: sys_r_line <= 0, exc=1 for one cycle.
- Write:
  - sys_write=1 at edge N -> register updated at edge N.
  - Invalid write: no state change, exc=1 for one cycle after edge N.
  - Writes to RO registers (ID, CYCLE) are ignored, no exception.
- Simultaneous read and write (sys_read and sys_write both 1):
  - Both are serviced.
  - The read returns the pre-write value, even for the same address.
  - exc = OR of both validity failures.
- Timer, evaluated each cycle while EN=1:
  - COUNT != 0: COUNT <= COUNT-1.
  - COUNT == 0: EXP <= 1. If AUTO=1, COUNT <= RELOAD; else EN <= 0 and COUNT stays 0.
- Priorities:
  - A bus write to COUNT beats the decrement/reload in the same cycle.
  - A bus write to CTRL beats the hardware EN clear.
  - An expiry in the same cycle as a STATUS W1C leaves EXP=1 (set wins).
- irq = EXP & IE, registered in step with STATUS (it updates at the same edge as EXP).
- EN=0: COUNT frozen; CYCLE keeps running.
- Arithmetic: COUNT decrement never underflows (0 handled above). CYCLE is modulo 2^32.

Test Plan:
- Reset then read BASE+0x00 -> sys_r_line=32'hC032_0001 one cycle later, exc=0; read BASE+0x14 -> 0.
- Write SCRATCH=32'hDEAD_BEEF, same cycle read SCRATCH -> 0 returned; next read -> 32'hDEAD_BEEF.
- Read BASE+0x20 and write BASE+0x06 -> exc high one cycle each, sys_r_line=0, SCRATCH unchanged.
- RELOAD=3, COUNT=3, CTRL=3'b111 -> COUNT runs 2,1,0, then EXP=1, irq=1 and COUNT=3 on the following edge; W1C STATUS -> irq=0.
- CTRL=3'b001 (one-shot), COUNT=1 -> after 2 cycles EXP=1, EN reads 0, COUNT stays 0, irq=0 (IE=0).
- Expiry coincident with STATUS write 1 -> EXP remains 1. Assert rst mid-countdown -> all registers 0 at that edge; CYCLE then restarts at 0.

Source files
------------

// File: rtl/sys_timer_responder.sv
// System-bus responder exposing an ID word, scratch register, free-running cycle
// counter and an auto-reloading down-counter timer with a level interrupt.
module sys_timer_responder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0100,
  parameter logic [31:0] ID_VALUE  = 32'hC032_0001
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] sys_r_addr,
  input  logic [31:0] sys_w_addr,
  input  logic [31:0] sys_w_line,
  input  logic        sys_read,
  input  logic        sys_write,
  output logic [31:0] sys_r_line,
  output logic        exc,
  output logic        irq
);

  localparam logic [2:0] OFF_ID      = 3'd0;
  localparam logic [2:0] OFF_CTRL    = 3'd1;
  localparam logic [2:0] OFF_COUNT   = 3'd2;
  localparam logic [2:0] OFF_RELOAD  = 3'd3;
  localparam logic [2:0] OFF_STATUS  = 3'd4;
  localparam logic [2:0] OFF_SCRATCH = 3'd5;
  localparam logic [2:0] OFF_CYCLE   = 3'd6;

  logic [2:0]  ctrl_q, ctrl_d;
  logic [31:0] count_q, count_d;
  logic [31:0] reload_q, reload_d;
  logic        exp_q, exp_d;
  logic [31:0] scratch_q, scratch_d;
  logic [31:0] cycle_q, cycle_d;
  logic [31:0] r_line_q, r_line_d;
  logic        exc_q, exc_d;
  logic        irq_q, irq_d;

  logic [31:0] r_rel, w_rel;
  logic        r_valid, w_valid;
  logic [2:0]  r_off, w_off;
  logic [31:0] r_data;
  logic        exp_set;

  // Offsets are taken relative to BASE_ADDR so the window need not be 32-byte aligned.
  assign r_rel   = sys_r_addr - BASE_ADDR;
  assign w_rel   = sys_w_addr - BASE_ADDR;
  assign r_valid = (sys_r_addr >= BASE_ADDR) && (r_rel <= 32'h1F) && (sys_r_addr[1:0] == 2'b00);
  assign w_valid = (sys_w_addr >= BASE_ADDR) && (w_rel <= 32'h1F) && (sys_w_addr[1:0] == 2'b00);
  assign r_off   = r_rel[4:2];
  assign w_off   = w_rel[4:2];

  always_comb begin
    r_data = 32'h0;
    case (r_off)
      OFF_ID:      r_data = ID_VALUE;
      OFF_CTRL:    r_data = {29'h0, ctrl_q};
      OFF_COUNT:   r_data = count_q;
      OFF_RELOAD:  r_data = reload_q;
      OFF_STATUS:  r_data = {31'h0, exp_q};
      OFF_SCRATCH: r_data = scratch_q;
      OFF_CYCLE:   r_data = cycle_q;
      default:     r_data = 32'h0;
    endcase
  end

  always_comb begin
    ctrl_d    = ctrl_q;
    count_d   = count_q;
    reload_d  = reload_q;
    exp_d     = exp_q;
    scratch_d = scratch_q;
    cycle_d   = cycle_q + 32'd1;
    r_line_d  = r_line_q;
    exp_set   = 1'b0;

    if (ctrl_q[0]) begin
      if (count_q != 32'h0) begin
        count_d = count_q - 32'd1;
      end else begin
        exp_set = 1'b1;
        if (ctrl_q[1]) count_d = reload_q;
        else           ctrl_d[0] = 1'b0;
      end
    end

    // Bus writes are applied after the timer so they take priority over it.
    if (sys_write && w_valid) begin
      case (w_off)
        OFF_CTRL:    ctrl_d    = sys_w_line[2:0];
        OFF_COUNT:   count_d   = sys_w_line;
        OFF_RELOAD:  reload_d  = sys_w_line;
        OFF_STATUS:  if (sys_w_line[0]) exp_d = 1'b0;
        OFF_SCRATCH: scratch_d = sys_w_line;
        default:     ;
      endcase
    end

    if (exp_set) exp_d = 1'b1;

    if (sys_read) r_line_d = r_valid ? r_data : 32'h0;

    exc_d = (sys_read && !r_valid) || (sys_write && !w_valid);
    irq_d = exp_d & ctrl_d[2];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ctrl_q    <= 3'h0;
      count_q   <= 32'h0;
      reload_q  <= 32'h0;
      exp_q     <= 1'b0;
      scratch_q <= 32'h0;
      cycle_q   <= 32'h0;
      r_line_q  <= 32'h0;
      exc_q     <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      ctrl_q    <= ctrl_d;
      count_q   <= count_d;
      reload_q  <= reload_d;
      exp_q     <= exp_d;
      scratch_q <= scratch_d;
      cycle_q   <= cycle_d;
      r_line_q  <= r_line_d;
      exc_q     <= exc_d;
      irq_q     <= irq_d;
    end
  end

  assign sys_r_line = r_line_q;
  assign exc        = exc_q;
  assign irq        = irq_q;

endmodule

// File: tb/tb_sys_timer_responder.sv
// Directed self-checking bench for sys_timer_responder: one task per feature,
// every bus operation occupying exactly one clock (driven and sampled at negedge).
module tb_sys_timer_responder;

  localparam logic [31:0] BASE = 32'h0000_0100;
  localparam logic [31:0] ID   = 32'hC032_0001;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] sys_r_addr = 32'h0;
  logic [31:0] sys_w_addr = 32'h0;
  logic [31:0] sys_w_line = 32'h0;
  logic        sys_read = 1'b0;
  logic        sys_write = 1'b0;
  logic [31:0] sys_r_line;
  logic        exc;
  logic        irq;

  int n_cmp = 0;
  int n_err = 0;

  sys_timer_responder #(.BASE_ADDR(BASE), .ID_VALUE(ID)) dut (
    .clk(clk), .rst(rst),
    .sys_r_addr(sys_r_addr), .sys_w_addr(sys_w_addr), .sys_w_line(sys_w_line),
    .sys_read(sys_read), .sys_write(sys_write),
    .sys_r_line(sys_r_line), .exc(exc), .irq(irq)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Bus drivers: called at a negedge, return at the following negedge.
  task automatic bus_rw(input logic rd, input logic [31:0] ra,
                        input logic wr, input logic [31:0] wa, input logic [31:0] wd,
                        output logic [31:0] d, output logic e);
    sys_read = rd; sys_r_addr = ra;
    sys_write = wr; sys_w_addr = wa; sys_w_line = wd;
    @(negedge clk);
    sys_read = 1'b0; sys_write = 1'b0;
    d = sys_r_line; e = exc;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d, output logic e);
    bus_rw(1'b1, a, 1'b0, 32'h0, 32'h0, d, e);
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] wd, output logic e);
    logic [31:0] d;
    bus_rw(1'b0, 32'h0, 1'b1, a, wd, d, e);
  endtask

  task automatic idle();
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [31:0] d; logic e;
    idle(); idle();
    n_cmp++; if (sys_r_line !== 32'h0) begin n_err++; $display("FAIL reset_rline: got %h want %h", sys_r_line, 32'h0); end
    n_cmp++; if (exc !== 1'b0) begin n_err++; $display("FAIL reset_exc: got %b want 0", exc); end
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL reset_irq: got %b want 0", irq); end
    rst = 1'b1;
    bus_read(BASE + 32'h00, d, e);
    $display("read ID      -> %h exc=%b", d, e);
    n_cmp++; if (d !== ID) begin n_err++; $display("FAIL id_read: got %h want %h", d, ID); end
    n_cmp++; if (e !== 1'b0) begin n_err++; $display("FAIL id_exc: got %b want 0", e); end
    bus_read(BASE + 32'h14, d, e);
    $display("read SCRATCH -> %h", d);
    n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL scratch_reset: got %h want 0", d); end
  endtask

  task automatic test_scratch();
    logic [31:0] d; logic e;
    bus_rw(1'b1, BASE + 32'h14, 1'b1, BASE + 32'h14, 32'hDEAD_BEEF, d, e);
    $display("rw SCRATCH   -> %h exc=%b", d, e);
    n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL scratch_prewrite: got %h want 0", d); end
    n_cmp++; if (e !== 1'b0) begin n_err++; $display("FAIL scratch_rw_exc: got %b want 0", e); end
    bus_read(BASE + 32'h14, d, e);
    $display("read SCRATCH -> %h", d);
    n_cmp++; if (d !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL scratch_read: got %h want deadbeef", d); end
    bus_write(BASE + 32'h00, 32'h1234_5678, e);
    bus_read(BASE + 32'h00, d, e);
    $display("read ID after write -> %h exc=%b", d, e);
    n_cmp++; if (d !== ID) begin n_err++; $display("FAIL id_ro: got %h want %h", d, ID); end
    n_cmp++; if (e !== 1'b0) begin n_err++; $display("FAIL id_ro_exc: got %b want 0", e); end
  endtask

  task automatic test_exceptions();
    logic [31:0] d; logic e;
    bus_read(BASE + 32'h20, d, e);
    $display("read BASE+20 -> %h exc=%b", d, e);
    n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL oob_read_data: got %h want 0", d); end
    n_cmp++; if (e !== 1'b1) begin n_err++; $display("FAIL oob_read_exc: got %b want 1", e); end
    idle();
    n_cmp++; if (exc !== 1'b0) begin n_err++; $display("FAIL exc_pulse: got %b want 0", exc); end
    bus_write(BASE + 32'h06, 32'h1111_1111, e);
    $display("write BASE+06 -> exc=%b", e);
    n_cmp++; if (e !== 1'b1) begin n_err++; $display("FAIL misaligned_write_exc: got %b want 1", e); end
    bus_read(BASE + 32'h14, d, e);
    $display("read SCRATCH -> %h", d);
    n_cmp++; if (d !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL scratch_unchanged: got %h want deadbeef", d); end
    bus_read(BASE + 32'h1C, d, e);
    $display("read BASE+1C -> %h exc=%b", d, e);
    n_cmp++; if (d !== 32'h0 || e !== 1'b0) begin n_err++; $display("FAIL reserved_read: got %h/%b want 0/0", d, e); end
    bus_read(BASE - 32'h4, d, e);
    $display("read BASE-4  -> %h exc=%b", d, e);
    n_cmp++; if (e !== 1'b1) begin n_err++; $display("FAIL below_base_exc: got %b want 1", e); end
    bus_rw(1'b1, BASE + 32'h14, 1'b1, BASE + 32'h40, 32'h0, d, e);
    $display("rw good-read/bad-write -> %h exc=%b", d, e);
    n_cmp++; if (d !== 32'hDEAD_BEEF || e !== 1'b1) begin n_err++; $display("FAIL rw_exc_or: got %h/%b want deadbeef/1", d, e); end
  endtask

  task automatic test_auto_reload();
    logic [31:0] d; logic e;
    logic [31:0] exp_seq [5] = '{32'd3, 32'd2, 32'd1, 32'd0, 32'd3};
    bus_write(BASE + 32'h0C, 32'd3, e);
    bus_write(BASE + 32'h08, 32'd3, e);
    bus_write(BASE + 32'h04, 32'h7, e);
    for (int i = 0; i < 5; i++) begin
      bus_read(BASE + 32'h08, d, e);
      $display("read COUNT[%0d] -> %0d irq=%b", i, d, irq);
      n_cmp++; if (d !== exp_seq[i]) begin n_err++; $display("FAIL count_seq%0d: got %0d want %0d", i, d, exp_seq[i]); end
      if (i == 3) begin
        n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL irq_on_expiry: got %b want 1", irq); end
      end
    end
    bus_write(BASE + 32'h10, 32'h1, e);
    $display("W1C STATUS -> irq=%b", irq);
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL irq_cleared: got %b want 0", irq); end
    bus_write(BASE + 32'h04, 32'h0, e);
    bus_read(BASE + 32'h10, d, e);
    n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL status_after_w1c: got %h want 0", d); end
  endtask

  task automatic test_one_shot();
    logic [31:0] d; logic e;
    bus_write(BASE + 32'h08, 32'd1, e);
    bus_write(BASE + 32'h04, 32'h1, e);
    idle(); idle();
    bus_read(BASE + 32'h10, d, e);
    $display("one-shot STATUS -> %h irq=%b", d, irq);
    n_cmp++; if (d !== 32'h1) begin n_err++; $display("FAIL oneshot_exp: got %h want 1", d); end
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL oneshot_irq_masked: got %b want 0", irq); end
    bus_read(BASE + 32'h04, d, e);
    $display("one-shot CTRL -> %h", d);
    n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL oneshot_en_cleared: got %h want 0", d); end
    bus_read(BASE + 32'h08, d, e);
    $display("one-shot COUNT -> %h", d);
    n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL oneshot_count: got %h want 0", d); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d, d0; logic e;
    bus_write(BASE + 32'h10, 32'h1, e);
    bus_write(BASE + 32'h08, 32'd2, e);
    bus_write(BASE + 32'h04, 32'h1, e);
    idle(); idle();
    bus_write(BASE + 32'h10, 32'h1, e);
    bus_read(BASE + 32'h10, d, e);
    $display("coincident W1C STATUS -> %h", d);
    n_cmp++; if (d !== 32'h1) begin n_err++; $display("FAIL set_beats_clear: got %h want 1", d); end
    bus_read(BASE + 32'h18, d0, e);
    bus_read(BASE + 32'h18, d, e);
    $display("CYCLE b2b -> %0d then %0d", d0, d);
    n_cmp++; if (d !== d0 + 32'd1) begin n_err++; $display("FAIL cycle_incr: got %0d want %0d", d, d0 + 32'd1); end
  endtask

  task automatic test_reset_mid_count();
    logic [31:0] d; logic e;
    logic [31:0] regs [5] = '{32'h04, 32'h08, 32'h0C, 32'h10, 32'h14};
    bus_write(BASE + 32'h14, 32'h0000_1234, e);
    bus_write(BASE + 32'h0C, 32'd5, e);
    bus_write(BASE + 32'h08, 32'd5, e);
    bus_write(BASE + 32'h04, 32'h7, e);
    bus_read(BASE + 32'h14, d, e);
    idle();
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    $display("mid-count reset -> rline=%h exc=%b irq=%b", sys_r_line, exc, irq);
    n_cmp++; if (sys_r_line !== 32'h0) begin n_err++; $display("FAIL midreset_rline: got %h want 0", sys_r_line); end
    bus_read(BASE + 32'h18, d, e);
    n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL cycle_restart0: got %0d want 0", d); end
    bus_read(BASE + 32'h18, d, e);
    n_cmp++; if (d !== 32'h1) begin n_err++; $display("FAIL cycle_restart1: got %0d want 1", d); end
    for (int i = 0; i < 5; i++) begin
      bus_read(BASE + regs[i], d, e);
      $display("post-reset read +%h -> %h", regs[i], d);
      n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL midreset_reg_%h: got %h want 0", regs[i], d); end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_scratch();
    test_exceptions();
    test_auto_reload();
    test_one_shot();
    test_back_to_back();
    test_reset_mid_count();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
